cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Run-control sequencer for the single-cycle CPU. It produces the clock enable `cpuEn` that gates every architectural state update in the CPU: PC, register file and data memory. It supports halt, single-step, N-cycle burst, free-run and a PC breakpoint. It sits between the debounced board inputs (buttons/switches) and the CPU, and exports status and cycle counters for the hex/LED debug displays.

Parameters:
PC_W, 32, width of PC and breakpoint address
BURST_W, 16, width of burst length
CNT_W, 32, width of the enabled-cycle counter

Ports:
cpuClk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
stepReq  in  1  level request (debounced); rising edge = execute one instruction
runReq  in  1  level request; rising edge = free-run
haltReq  in  1  level request; rising edge = stop
burstReq  in  1  level request; rising edge = run burstLen instructions
burstLen  in  BURST_W  burst length, sampled on accepted burstReq edge
bpEnable  in  1  breakpoint armed
bpAddr  in  PC_W  breakpoint PC
pcIn  in  PC_W  current CPU PC (pcOut of CPU)
cpuEn  out  1  CPU clock enable; combinational from state and PC compare
halted  out  1  1 when state==HALT
haltCause  out  2  0 reset, 1 step/halt request, 2 breakpoint, 3 burst done
burstLeft  out  BURST_W  remaining burst instructions
cycleCount  out  CNT_W  number of cycles with cpuEn=1

Behaviour:
- Reset is asynchronous on `rst`; `cpuClk` is the clock.
- Reset values:
  - state=HALT, cpuEn=0, halted=1, haltCause=0, burstLeft=0, cycleCount=0.
  - Edge-detect history registers reset to 1, so a request held through reset does not fire.
- Edge detect: edge_x = x & ~x_prev, registered each cycle. All requests are level inputs synchronous to cpuClk.
- bpHit = bpEnable & (pcIn==bpAddr) & ~skipBp.
- skipBp is set to 1 on every HALT->{STEP,RUN,BURST} transition and cleared after the first enabled cycle. This lets the CPU resume from a breakpoint PC.
- States: HALT, STEP, RUN, BURST.
- HALT:
  - cpuEn=0.
  - Priority when several edges arrive in one cycle: haltEdge (ignored, stays HALT) > stepEdge -> STEP > burstEdge -> BURST > runEdge -> RUN.
  - On burstEdge, burstLeft<=burstLen. If burstLen==0, stay HALT with haltCause=3.
- STEP:
  - cpuEn=1 for exactly one cycle, then HALT with haltCause=1.
  - Breakpoint is ignored (skipBp is set).
  - haltEdge in this cycle has no extra effect; the step still executes.
- RUN:
  - cpuEn = ~bpHit & ~haltEdge.
  - On haltEdge -> HALT, haltCause=1.
  - Else on bpHit -> HALT, haltCause=2; the instruction at bpAddr is NOT executed.
  - haltEdge takes precedence over bpHit when both occur.
- BURST:
  - cpuEn = ~bpHit & ~haltEdge.
  - Each enabled cycle decrements burstLeft.
  - When burstLeft==1 with cpuEn=1 -> HALT, haltCause=3, burstLeft=0.
  - haltEdge or bpHit -> HALT with causes as in RUN; burstLeft keeps its residual value.
- Edges of stepReq/runReq/burstReq outside HALT are discarded (not queued).
- cycleCount increments on every cycle with cpuEn=1 and wraps modulo 2^CNT_W.
- Latency:
  - Request edge at cycle t (input rises before edge t) -> state change at edge t+1 -> cpuEn=1 during cycle t+1.
  - The first CPU update happens at edge t+2.
- Reset mid-operation: cpuEn drops to 0 immediately (asynchronous), and all state returns to reset values.

Decomposition:
- Package cpu_run_ctrl_pkg holds the state encodings (HALT=0, STEP=1, RUN=2, BURST=3) and the haltCause constants (CAUSE_RESET, CAUSE_REQ, CAUSE_BP, CAUSE_BURST).
- One sub-module, req_edge: a per-input rising-edge detector with the history register reset to 1. It is instantiated four times.

Test Plan:
- Reset with stepReq held high, then release rst -> no step; halted=1, cpuEn=0, cycleCount=0, haltCause=0.
- In HALT, pulse stepReq 0->1 -> cpuEn=1 for exactly 1 cycle, cycleCount=1, haltCause=1. A second stepReq rise gives cycleCount=2.
- burstLen=5, burstReq edge -> cpuEn=1 for 5 consecutive cycles, burstLeft 5,4,3,2,1,0, then halted=1, haltCause=3, cycleCount+=5. A burst with burstLen=0 gives zero enabled cycles and haltCause=3.
- bpEnable=1, bpAddr=0x0000000C, PC stepping by 4 from 0, runReq edge -> enabled cycles at PC 0,4,8. With pcIn=0xC, cpuEn=0, haltCause=2. A following runReq edge executes PC 0xC (skipBp), then continues.
- During RUN, haltReq edge and bpHit in the same cycle -> cpuEn=0, haltCause=1. Simultaneous step+run edges in HALT -> STEP taken, one cycle only.
- Preload cycleCount near wrap (run 2^CNT_W-1 cycles with CNT_W overridden to 4: 15 cycles), then one more step -> cycleCount=0. Assert rst mid-BURST -> cpuEn=0 in the same cycle, burstLeft=0.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run-control sequencer: state encodings,
// halt-cause codes and the rising-edge helper used by the request detectors.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_STEP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_BURST = 2'd3
  } run_state_e;

  localparam logic [1:0] CAUSE_RESET = 2'd0;
  localparam logic [1:0] CAUSE_REQ   = 2'd1;
  localparam logic [1:0] CAUSE_BP    = 2'd2;
  localparam logic [1:0] CAUSE_BURST = 2'd3;

  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Request/status bundle between the board-side debug inputs and the run
// controller; master drives requests, slave (the controller) drives status.
interface cpu_run_ctrl_if #(
  parameter int PC_W    = 32,
  parameter int BURST_W = 16,
  parameter int CNT_W   = 32
);
  logic               stepReq;
  logic               runReq;
  logic               haltReq;
  logic               burstReq;
  logic [BURST_W-1:0] burstLen;
  logic               bpEnable;
  logic [PC_W-1:0]    bpAddr;
  logic [PC_W-1:0]    pcIn;

  logic               cpuEn;
  logic               halted;
  logic [1:0]         haltCause;
  logic [BURST_W-1:0] burstLeft;
  logic [CNT_W-1:0]   cycleCount;

  modport master (
    output stepReq, runReq, haltReq, burstReq, burstLen,
    output bpEnable, bpAddr, pcIn,
    input  cpuEn, halted, haltCause, burstLeft, cycleCount
  );

  modport slave (
    input  stepReq, runReq, haltReq, burstReq, burstLen,
    input  bpEnable, bpAddr, pcIn,
    output cpuEn, halted, haltCause, burstLeft, cycleCount
  );

endinterface

// File: rtl/cpu_run_ctrl_req_edge.sv
// Registered rising-edge detector for one debounced request level. History
// resets to 1 so a request already high through reset never fires.
module req_edge
  import cpu_run_ctrl_pkg::*;
(
  input  logic cpuClk,
  input  logic rst,
  input  logic i_level,
  output logic o_edge
);

  logic r_prev;
  logic r_edge;

  always_ff @(posedge cpuClk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b1;
      r_edge <= 1'b0;
    end else begin
      r_prev <= i_level;
      r_edge <= rise(i_level, r_prev);
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: generates the CPU clock enable for halt, single-step,
// N-instruction burst, free-run and PC-breakpoint operation.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int BURST_W = 16,
  parameter int CNT_W   = 32
) (
  input  logic           cpuClk,
  input  logic           rst,
  cpu_run_ctrl_if.slave  io_ctl
);

  logic w_stepEdge;
  logic w_runEdge;
  logic w_haltEdge;
  logic w_burstEdge;

  req_edge u_step_edge  (.cpuClk(cpuClk), .rst(rst), .i_level(io_ctl.stepReq),  .o_edge(w_stepEdge));
  req_edge u_run_edge   (.cpuClk(cpuClk), .rst(rst), .i_level(io_ctl.runReq),   .o_edge(w_runEdge));
  req_edge u_halt_edge  (.cpuClk(cpuClk), .rst(rst), .i_level(io_ctl.haltReq),  .o_edge(w_haltEdge));
  req_edge u_burst_edge (.cpuClk(cpuClk), .rst(rst), .i_level(io_ctl.burstReq), .o_edge(w_burstEdge));

  run_state_e         r_state;
  run_state_e         w_stateNext;
  logic               r_skipBp;
  logic               w_skipBpNext;
  logic [1:0]         r_cause;
  logic [1:0]         w_causeNext;
  logic [BURST_W-1:0] r_burstLeft;
  logic [BURST_W-1:0] w_burstLeftNext;
  logic [CNT_W-1:0]   r_cycleCount;
  logic [PC_W-1:0]    w_pcDiff;
  logic               w_bpHit;
  logic               w_cpuEn;

  assign w_pcDiff = io_ctl.pcIn ^ io_ctl.bpAddr;
  // skipBp lets execution resume from the PC that caused the breakpoint halt
  assign w_bpHit  = io_ctl.bpEnable & ~(|w_pcDiff) & ~r_skipBp;

  always_comb begin
    w_stateNext     = r_state;
    w_causeNext     = r_cause;
    w_burstLeftNext = r_burstLeft;
    w_skipBpNext    = r_skipBp;
    w_cpuEn         = 1'b0;

    case (r_state)
      ST_HALT: begin
        if (w_haltEdge) begin
          w_stateNext = ST_HALT;
        end else if (w_stepEdge) begin
          w_stateNext  = ST_STEP;
          w_skipBpNext = 1'b1;
        end else if (w_burstEdge) begin
          w_burstLeftNext = io_ctl.burstLen;
          if (io_ctl.burstLen == '0) begin
            w_causeNext = CAUSE_BURST;
          end else begin
            w_stateNext  = ST_BURST;
            w_skipBpNext = 1'b1;
          end
        end else if (w_runEdge) begin
          w_stateNext  = ST_RUN;
          w_skipBpNext = 1'b1;
        end
      end

      ST_STEP: begin
        w_cpuEn     = 1'b1;
        w_stateNext = ST_HALT;
        w_causeNext = CAUSE_REQ;
      end

      ST_RUN: begin
        w_cpuEn = ~w_bpHit & ~w_haltEdge;
        if (w_haltEdge) begin
          w_stateNext = ST_HALT;
          w_causeNext = CAUSE_REQ;
        end else if (w_bpHit) begin
          w_stateNext = ST_HALT;
          w_causeNext = CAUSE_BP;
        end
      end

      ST_BURST: begin
        w_cpuEn = ~w_bpHit & ~w_haltEdge;
        if (w_haltEdge) begin
          w_stateNext = ST_HALT;
          w_causeNext = CAUSE_REQ;
        end else if (w_bpHit) begin
          w_stateNext = ST_HALT;
          w_causeNext = CAUSE_BP;
        end else begin
          w_burstLeftNext = r_burstLeft - BURST_W'(1);
          if (r_burstLeft == BURST_W'(1)) begin
            w_stateNext = ST_HALT;
            w_causeNext = CAUSE_BURST;
          end
        end
      end

      default: begin
        w_stateNext = ST_HALT;
      end
    endcase

    if (w_cpuEn) begin
      w_skipBpNext = 1'b0;
    end
  end

  always_ff @(posedge cpuClk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_HALT;
      r_skipBp     <= 1'b0;
      r_cause      <= CAUSE_RESET;
      r_burstLeft  <= '0;
      r_cycleCount <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_skipBp    <= w_skipBpNext;
      r_cause     <= w_causeNext;
      r_burstLeft <= w_burstLeftNext;
      if (w_cpuEn) begin
        r_cycleCount <= r_cycleCount + CNT_W'(1);
      end
    end
  end

  assign io_ctl.cpuEn      = w_cpuEn;
  assign io_ctl.halted     = (r_state == ST_HALT);
  assign io_ctl.haltCause  = r_cause;
  assign io_ctl.burstLeft  = r_burstLeft;
  assign io_ctl.cycleCount = r_cycleCount;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios followed by random
// request traffic, all checked against a budget-based behavioural model.
module tb_cpu_run_ctrl;

  localparam int PC_W    = 32;
  localparam int BURST_W = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic cpuClk = 1'b0;
  logic rst    = 1'b1;

  cpu_run_ctrl_if #(.PC_W(PC_W), .BURST_W(BURST_W), .CNT_W(CNT_W)) ctl ();

  cpu_run_ctrl #(.PC_W(PC_W), .BURST_W(BURST_W), .CNT_W(CNT_W)) dut (
    .cpuClk (cpuClk),
    .rst    (rst),
    .io_ctl (ctl)
  );

  always #5 cpuClk = ~cpuClk;

  int errors = 0;
  int checks = 0;

  // Model: an active "job" with an instruction budget (-1 = unlimited).
  // A step is a job of budget 1 that nothing can interrupt.
  bit          m_act;
  bit          m_unint;
  int          m_budget;
  int          m_cause;
  int          m_bleft;
  int          m_count;
  bit          m_skip;
  bit [3:0]    m_prev;   // {burst, halt, run, step}
  bit [3:0]    m_pend;
  logic [31:0] pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [3:0] levels();
    return {ctl.burstReq, ctl.haltReq, ctl.runReq, ctl.stepReq};
  endfunction

  task automatic model_reset();
    m_act = 0; m_unint = 0; m_budget = 0; m_cause = 0; m_bleft = 0;
    m_count = 0; m_skip = 0; m_prev = 4'hF; m_pend = 4'h0;
  endtask

  task automatic start_job(input int budget, input bit unint);
    m_act = 1; m_budget = budget; m_unint = unint; m_skip = 1;
  endtask

  function automatic bit exp_en();
    bit hit;
    hit = ctl.bpEnable && (ctl.pcIn == ctl.bpAddr) && !m_skip;
    return m_act && (m_unint || (!hit && !m_pend[2]));
  endfunction

  task automatic advance(input bit en);
    if (m_act) begin
      if (en) begin
        m_count = (m_count + 1) % CNT_MOD;
        m_skip  = 0;
        if (m_budget > 0) begin
          m_budget--;
          if (!m_unint) m_bleft--;
          if (m_budget == 0) begin
            m_act   = 0;
            m_cause = m_unint ? 1 : 3;
          end
        end
      end else begin
        m_act   = 0;
        m_cause = m_pend[2] ? 1 : 2;
      end
    end else if (!m_pend[2]) begin
      if (m_pend[0]) start_job(1, 1);
      else if (m_pend[3]) begin
        m_bleft = int'(ctl.burstLen);
        if (ctl.burstLen == 0) m_cause = 3;
        else start_job(int'(ctl.burstLen), 0);
      end else if (m_pend[1]) start_job(-1, 0);
    end
    m_pend = levels() & ~m_prev;
    m_prev = levels();
  endtask

  // One clock cycle: check outputs mid-cycle, step the model, then let the
  // bench "CPU" advance its PC if the model expects an enabled cycle.
  task automatic cycle();
    bit en;
    #1;
    en = exp_en();
    check("cpuEn",      ctl.cpuEn,      en);
    check("halted",     ctl.halted,     !m_act);
    check("haltCause",  ctl.haltCause,  m_cause);
    check("burstLeft",  ctl.burstLeft,  m_bleft);
    check("cycleCount", ctl.cycleCount, m_count);
    advance(en);
    @(posedge cpuClk);
    #1;
    if (en) pc = pc + 32'd4;
    ctl.pcIn = pc;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int snap;
  int n;

  initial begin
    ctl.stepReq = 1'b1; ctl.runReq = 1'b0; ctl.haltReq = 1'b0; ctl.burstReq = 1'b0;
    ctl.burstLen = 16'd5; ctl.bpEnable = 1'b0; ctl.bpAddr = 32'hC;
    pc = 32'd0; ctl.pcIn = pc;
    model_reset();

    repeat (2) @(posedge cpuClk);
    #2;
    check("rst_cpuEn",  ctl.cpuEn,  1'b0);
    check("rst_halted", ctl.halted, 1'b1);
    @(posedge cpuClk);
    #1;
    rst = 1'b0;

    // stepReq held through reset must not fire
    cycles(4);
    check("held_step_count", ctl.cycleCount, 0);
    check("held_step_cause", ctl.haltCause, 0);

    ctl.stepReq = 1'b0; cycles(2);
    ctl.stepReq = 1'b1; cycles(4);
    check("step1_count", ctl.cycleCount, 1);
    check("step1_cause", ctl.haltCause, 1);
    ctl.stepReq = 1'b0; cycle();
    ctl.stepReq = 1'b1; cycles(4);
    check("step2_count", ctl.cycleCount, 2);
    ctl.stepReq = 1'b0;

    // burst of 5, then zero-length burst
    ctl.burstLen = 16'd5; ctl.burstReq = 1'b1; cycles(9);
    ctl.burstReq = 1'b0; cycle();
    check("burst5_count", ctl.cycleCount, 7);
    check("burst5_cause", ctl.haltCause, 3);
    check("burst5_left",  ctl.burstLeft, 0);
    ctl.stepReq = 1'b1; cycles(3); ctl.stepReq = 1'b0; cycle();
    ctl.burstLen = 16'd0; ctl.burstReq = 1'b1; cycles(4);
    ctl.burstReq = 1'b0; cycle();
    check("burst0_cause", ctl.haltCause, 3);
    check("burst0_count", ctl.cycleCount, 8);

    // breakpoint at 0xC while free-running from PC 0
    pc = 32'd0; ctl.pcIn = pc;
    ctl.bpEnable = 1'b1; ctl.bpAddr = 32'hC;
    ctl.runReq = 1'b1; cycles(7);
    ctl.runReq = 1'b0; cycle();
    check("bp_cause",  ctl.haltCause, 2);
    check("bp_pc",     ctl.pcIn, 32'hC);
    check("bp_halted", ctl.halted, 1'b1);
    ctl.runReq = 1'b1; cycles(5);
    ctl.runReq = 1'b0;
    // halt edge lands in the same cycle the PC reaches the breakpoint
    ctl.bpAddr = pc + 32'd4; ctl.haltReq = 1'b1; cycles(3);
    ctl.haltReq = 1'b0; cycle();
    check("halt_over_bp_cause", ctl.haltCause, 1);

    // simultaneous step + run edges: only one step
    snap = m_count;
    ctl.bpEnable = 1'b0;
    ctl.stepReq = 1'b1; ctl.runReq = 1'b1; cycles(5);
    ctl.stepReq = 1'b0; ctl.runReq = 1'b0; cycle();
    check("step_run_count", ctl.cycleCount, (snap + 1) % CNT_MOD);
    check("step_run_halted", ctl.halted, 1'b1);

    // drive the counter to its maximum, then one step wraps it to zero
    n = (CNT_MOD - 1 - m_count) % CNT_MOD;
    if (n != 0) begin
      ctl.burstLen = 16'(n); ctl.burstReq = 1'b1; cycles(n + 4);
      ctl.burstReq = 1'b0; cycle();
    end
    check("pre_wrap_count", ctl.cycleCount, CNT_MOD - 1);
    ctl.stepReq = 1'b1; cycles(4); ctl.stepReq = 1'b0; cycle();
    check("wrap_count", ctl.cycleCount, 0);

    // reset in the middle of a burst
    ctl.burstLen = 16'd9; ctl.burstReq = 1'b1; cycles(4);
    check("pre_rst_cpuEn", ctl.cpuEn, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_cpuEn",     ctl.cpuEn,      1'b0);
    check("midrst_burstLeft", ctl.burstLeft,  0);
    check("midrst_halted",    ctl.halted,     1'b1);
    check("midrst_count",     ctl.cycleCount, 0);
    check("midrst_cause",     ctl.haltCause,  0);
    ctl.burstReq = 1'b0;
    @(posedge cpuClk);
    #1;
    rst = 1'b0;
    model_reset();
    cycles(3);

    // random request traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) ctl.stepReq  = ~ctl.stepReq;
      if ($urandom_range(0, 5) == 0) ctl.runReq   = ~ctl.runReq;
      if ($urandom_range(0, 9) == 0) ctl.haltReq  = ~ctl.haltReq;
      if ($urandom_range(0, 5) == 0) ctl.burstReq = ~ctl.burstReq;
      if ($urandom_range(0, 7) == 0) ctl.burstLen = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) ctl.bpEnable = ~ctl.bpEnable;
      if ($urandom_range(0, 7) == 0) ctl.bpAddr = pc + 32'(4 * $urandom_range(0, 3));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
